// File: rtl/adc_collect_pkg.sv
// adc_collect_pkg: constants, types and the read-word packing helper shared by
// adc_sample_collector and its per-channel accumulator.
package adc_collect_pkg;

  localparam int DATA_W_DFLT = 12;
  localparam int CH_W        = 5;

  // Read word layout: unread flag in the MSB, result right-aligned below it.
  localparam int RD_W        = 32;
  localparam int FLAG_BIT    = 31;
  localparam int RESULT_LSB  = 0;
  localparam int RESULT_W    = FLAG_BIT - RESULT_LSB;

  // A channel result as presented to the read mux (zero-extended).
  typedef logic [RESULT_W-1:0] result_t;
  typedef logic [RD_W-1:0]     rd_word_t;

  function automatic rd_word_t pack_rd(input logic flag, input result_t result);
    rd_word_t w;
    w = '0;
    w[FLAG_BIT] = flag;
    w[RESULT_LSB +: RESULT_W] = result;
    return w;
  endfunction

endpackage

// File: rtl/adc_ch_accum.sv
// adc_ch_accum: one channel's sample accumulator, sample counter and result
// register. `done` pulses in the cycle whose sample completes a result.
// With ADC_COLLECT_AVG_EN defined the result is the boxcar average of
// 2**AVG_LOG2 samples; otherwise every accepted sample is stored directly and
// no accumulator or counter is built.
module adc_ch_accum
  import adc_collect_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DFLT,
  parameter int AVG_LOG2 = 3
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic              enable,
  input  logic              sample_vld,
  input  logic [DATA_W-1:0] sample_data,
  output logic              done,
  output result_t           result
);

  if (AVG_LOG2 < 0 || AVG_LOG2 > 6) begin : g_bad_avg_log2
    $error("adc_ch_accum: AVG_LOG2 must be in 0..6");
  end

  logic              accept;
  logic [DATA_W-1:0] res_q, res_d;

  assign accept = enable & sample_vld;

`ifdef ADC_COLLECT_AVG_EN
  // Accumulator is wide enough for 2**AVG_LOG2 full-scale samples.
  localparam int ACC_W = DATA_W + AVG_LOG2;
  // AVG_LOG2=0 still needs a 1-bit counter; it simply never leaves 0.
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0] acc_q, acc_d, sum;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Accumulate accepted samples; on the last one publish the truncated mean.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    res_d = res_q;
    done  = 1'b0;
    sum   = acc_q + ACC_W'(sample_data);
    if (!enable) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      if (cnt_q == CNT_LAST) begin
        res_d = DATA_W'(sum >> AVG_LOG2);
        acc_d = '0;
        cnt_d = '0;
        done  = 1'b1;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Accumulator, counter and result registers.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      res_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
    end
  end
`else
  // Every accepted sample is a complete result.
  always_comb begin
    res_d = res_q;
    done  = 1'b0;
    if (accept) begin
      res_d = sample_data;
      done  = 1'b1;
    end
  end

  // Result register.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      res_q <= '0;
    end else begin
      res_q <= res_d;
    end
  end
`endif

  assign result = result_t'(res_q);

endmodule

// File: rtl/adc_sample_collector.sv
// adc_sample_collector: collects the ADC response stream per channel, keeps
// the latest result per channel with sticky unread flags and an overrun flag,
// and serves a one-cycle-latency read port.
// Optional feature macro: ADC_COLLECT_AVG_EN (boxcar averaging of 2**AVG_LOG2
// samples; when undefined each accepted sample is the result).
module adc_sample_collector
  import adc_collect_pkg::*;
#(
  parameter int  NUM_CH   = 8,
  parameter int  AVG_LOG2 = 3,
  parameter int  DATA_W   = DATA_W_DFLT,
  localparam int ADDR_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              Clock_qsys,
  input  logic              Reset,
  input  logic              Enable,
  input  logic              RspValid,
  input  logic [CH_W-1:0]   RspChannel,
  input  logic [DATA_W-1:0] RspData,
  input  logic              RdEn,
  input  logic [ADDR_W-1:0] RdAddress,
  output logic [RD_W-1:0]   RdData,
  output logic              RdValid,
  output logic [NUM_CH-1:0] NewData,
  output logic              Overrun,
  input  logic              OverrunClr
);

  if (NUM_CH < 1 || NUM_CH > 32) begin : g_bad_num_ch
    $error("adc_sample_collector: NUM_CH must be in 1..32");
  end

  logic [NUM_CH-1:0] ch_vld;
  logic [NUM_CH-1:0] ch_done;
  result_t           ch_result [NUM_CH];

  logic              rd_hit;
  logic [NUM_CH-1:0] rd_clr;

  logic [NUM_CH-1:0] new_data_q, new_data_d;
  logic              overrun_q, overrun_d;
  rd_word_t          rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  // Channels at or above NUM_CH never match a lane and are dropped here.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ch_vld[i] = RspValid && (RspChannel == CH_W'(i));

    adc_ch_accum #(
      .DATA_W   (DATA_W),
      .AVG_LOG2 (AVG_LOG2)
    ) u_accum (
      .clk_sys     (Clock_qsys),
      .rst         (Reset),
      .enable      (Enable),
      .sample_vld  (ch_vld[i]),
      .sample_data (RspData),
      .done        (ch_done[i]),
      .result      (ch_result[i])
    );
  end

  assign rd_hit = RdEn && (int'(RdAddress) < NUM_CH);

  // Read mux: latch flag+result of the addressed channel, zero for a bad address.
  always_comb begin
    rd_clr     = '0;
    rd_data_d  = rd_data_q;
    rd_valid_d = RdEn;
    if (RdEn) begin
      rd_data_d = '0;
    end
    if (rd_hit) begin
      rd_clr[RdAddress] = 1'b1;
      rd_data_d = pack_rd(new_data_q[RdAddress], ch_result[RdAddress]);
    end
  end

  // Flag update: a completion beats a read-clear; overrun only if the unread
  // result is really being replaced, and an overrun set beats OverrunClr.
  always_comb begin
    new_data_d = (new_data_q & ~rd_clr) | ch_done;
    overrun_d  = (|(ch_done & new_data_q & ~rd_clr)) | (overrun_q & ~OverrunClr);
  end

  // Flag and read-port registers.
  always_ff @(posedge Clock_qsys or posedge Reset) begin
    if (Reset) begin
      new_data_q <= '0;
      overrun_q  <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      new_data_q <= new_data_d;
      overrun_q  <= overrun_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign NewData = new_data_q;
  assign Overrun = overrun_q;
  assign RdData  = rd_data_q;
  assign RdValid = rd_valid_q;

endmodule

// File: tb/tb_adc_sample_collector.sv
// tb_adc_sample_collector: directed test of adc_sample_collector with a read
// scoreboard. Expected values follow the build: averaging of 8 samples when
// ADC_COLLECT_AVG_EN is defined, direct store of each sample otherwise.
module tb_adc_sample_collector;

`ifdef ADC_COLLECT_AVG_EN
  localparam bit AVG_EN = 1'b1;
`else
  localparam bit AVG_EN = 1'b0;
`endif
  // Samples needed to complete one result on a channel.
  localparam int N_CMP = AVG_EN ? 8 : 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        Enable;
  logic        RspValid;
  logic [4:0]  RspChannel;
  logic [11:0] RspData;
  logic        RdEn;
  logic [2:0]  RdAddress;
  logic [31:0] RdData;
  logic        RdValid;
  logic [7:0]  NewData;
  logic        Overrun;
  logic        OverrunClr;

  typedef struct {
    logic [31:0] data;
    int          due;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cycle    = 0;

  adc_sample_collector #(
    .NUM_CH   (8),
    .AVG_LOG2 (3),
    .DATA_W   (12)
  ) dut (
    .Clock_qsys (clk),
    .Reset      (rst),
    .Enable     (Enable),
    .RspValid   (RspValid),
    .RspChannel (RspChannel),
    .RspData    (RspData),
    .RdEn       (RdEn),
    .RdAddress  (RdAddress),
    .RdData     (RdData),
    .RdValid    (RdValid),
    .NewData    (NewData),
    .Overrun    (Overrun),
    .OverrunClr (OverrunClr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Monitor: every RdValid pulse must match the oldest outstanding read,
  // arriving exactly one cycle after it was issued.
  always @(negedge clk) begin
    exp_t e;
    if (RdValid === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL rd_unexpected: RdValid with RdData=%h, no read outstanding", RdData);
      end else begin
        e = exp_q.pop_front();
        if (RdData !== e.data || cycle != e.due) begin
          n_errors++;
          $display("FAIL %s: RdData=%h at cycle %0d, expected %h at cycle %0d",
                   e.name, RdData, cycle, e.data, e.due);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic vld, input logic [4:0] ch,
                       input logic [11:0] d, input logic rd, input logic [2:0] a,
                       input logic clr);
    Enable     = en;
    RspValid   = vld;
    RspChannel = ch;
    RspData    = d;
    RdEn       = rd;
    RdAddress  = a;
    OverrunClr = clr;
  endtask

  task automatic push_exp(input logic [31:0] e, input string nm);
    exp_t x;
    x.data = e;
    x.due  = cycle + 1;
    x.name = nm;
    exp_q.push_back(x);
  endtask

  task automatic smp(input logic [4:0] ch, input logic [11:0] d);
    @(negedge clk);
    drive(1'b1, 1'b1, ch, d, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic idle();
    @(negedge clk);
    drive(1'b1, 1'b0, 5'd0, 12'd0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic oclr();
    @(negedge clk);
    drive(1'b1, 1'b0, 5'd0, 12'd0, 1'b0, 3'd0, 1'b1);
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string nm);
    @(negedge clk);
    drive(1'b1, 1'b0, 5'd0, 12'd0, 1'b1, a, 1'b0);
    push_exp(e, nm);
  endtask

  task automatic rd_smp(input logic [2:0] a, input logic [4:0] ch, input logic [11:0] d,
                        input logic [31:0] e, input string nm);
    @(negedge clk);
    drive(1'b1, 1'b1, ch, d, 1'b1, a, 1'b0);
    push_exp(e, nm);
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b1, 1'b0, 5'd0, 12'd0, 1'b0, 3'd0, 1'b0);
    #1 rst = 1'b1;
    #2;
    chk("rst_rddata",  RdData,  32'h0);
    chk("rst_rdvalid", {31'd0, RdValid}, 32'h0);
    chk("rst_newdata", {24'd0, NewData}, 32'h0);
    chk("rst_overrun", {31'd0, Overrun}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // ch2: 0x100..0x107 back-to-back
    for (int i = 0; i < 8; i++) begin
      smp(5'd2, 12'(12'h100 + i));
      if (i == 7) chk("t1_nd_before_last", {24'd0, NewData}, AVG_EN ? 32'h0 : 32'h4);
    end
    idle();
    chk("t1_newdata", {24'd0, NewData}, 32'h4);
    chk("t1_overrun", {31'd0, Overrun}, AVG_EN ? 32'h0 : 32'h1);
    oclr();
    idle();
    chk("t1_overrun_clr", {31'd0, Overrun}, 32'h0);

    // read, flag clear, back-to-back reads, RdData hold
    rd(3'd2, AVG_EN ? 32'h8000_0103 : 32'h8000_0107, "t2_rd_ch2");
    idle();
    chk("t2_newdata_cleared", {24'd0, NewData}, 32'h0);
    rd(3'd5, 32'h0, "t2_rd_ch5_empty");
    rd(3'd2, AVG_EN ? 32'h0000_0103 : 32'h0000_0107, "t2_reread_ch2");
    idle();
    idle();
    chk("t2_rddata_hold", RdData, AVG_EN ? 32'h0000_0103 : 32'h0000_0107);

    // full-scale on ch0 interleaved with out-of-range channel 9
    for (int i = 0; i < 8; i++) begin
      smp(5'd0, 12'hFFF);
      smp(5'd9, 12'h001);
    end
    idle();
    chk("t3_newdata", {24'd0, NewData}, 32'h1);
    chk("t3_overrun", {31'd0, Overrun}, AVG_EN ? 32'h0 : 32'h1);
    rd(3'd1, 32'h0, "t3_ch1_untouched");
    rd(3'd0, 32'h8000_0FFF, "t3_rd_ch0");
    oclr();
    idle();
    chk("t3_overrun_clr", {31'd0, Overrun}, 32'h0);
    chk("t3_newdata_clr", {24'd0, NewData}, 32'h0);

    // overrun, clear, and completion coinciding with a read
    for (int i = 0; i < N_CMP; i++) smp(5'd0, 12'h020);
    idle();
    chk("t4_first_nd", {24'd0, NewData}, 32'h1);
    chk("t4_first_ovr", {31'd0, Overrun}, 32'h0);
    for (int i = 0; i < N_CMP; i++) smp(5'd0, 12'h030);
    idle();
    chk("t4_second_ovr", {31'd0, Overrun}, 32'h1);
    oclr();
    idle();
    chk("t4_ovr_clr", {31'd0, Overrun}, 32'h0);
    for (int i = 0; i < N_CMP - 1; i++) smp(5'd0, 12'h040);
    rd_smp(3'd0, 5'd0, 12'h040, 32'h8000_0030, "t4_rd_coincide");
    idle();
    chk("t4_coincide_nd", {24'd0, NewData}, 32'h1);
    chk("t4_coincide_ovr", {31'd0, Overrun}, 32'h0);
    rd(3'd0, 32'h8000_0040, "t4_rd_new");
    idle();
    chk("t4_nd_after_rd", {24'd0, NewData}, 32'h0);

    // partial sum discarded by Enable low (sample offered then is dropped)
    for (int i = 0; i < 5; i++) smp(5'd1, 12'h300);
    @(negedge clk);
    drive(1'b0, 1'b1, 5'd1, 12'hFFF, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 8; i++) smp(5'd1, 12'h010);
    idle();
    chk("t5_newdata", {24'd0, NewData}, 32'h2);
    chk("t5_overrun", {31'd0, Overrun}, AVG_EN ? 32'h0 : 32'h1);
    rd(3'd1, 32'h8000_0010, "t5_rd_ch1");
    oclr();
    idle();

    // async reset mid-accumulation and mid-read
    for (int i = 0; i < 8; i++) smp(5'd4, 12'h050);
    for (int i = 0; i < 3; i++) smp(5'd3, 12'h700);
    @(negedge clk);
    drive(1'b1, 1'b0, 5'd0, 12'd0, 1'b1, 3'd4, 1'b0);
    @(posedge clk);
    #1;
    chk("t6_rdvalid_pre", {31'd0, RdValid}, 32'h1);
    #1;
    rst = 1'b1;
    drive(1'b1, 1'b0, 5'd0, 12'd0, 1'b0, 3'd0, 1'b0);
    #1;
    chk("t6_rst_rddata",  RdData, 32'h0);
    chk("t6_rst_rdvalid", {31'd0, RdValid}, 32'h0);
    chk("t6_rst_newdata", {24'd0, NewData}, 32'h0);
    chk("t6_rst_overrun", {31'd0, Overrun}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) smp(5'd3, 12'h200);
    idle();
    chk("t6_newdata", {24'd0, NewData}, 32'h8);
    chk("t6_overrun", {31'd0, Overrun}, AVG_EN ? 32'h0 : 32'h1);
    rd(3'd4, 32'h0, "t6_rd_ch4_cleared");
    rd(3'd3, 32'h8000_0200, "t6_rd_ch3");
    idle();
    idle();
    chk("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/adc_sample_collector.md
# adc_sample_collector

Downstream consumer of the on-chip ADC's response stream, once the ADC is in continuous run mode. It accumulates a power-of-two number of samples per channel, stores the boxcar average per channel, and flags fresh results. A single-cycle-latency read port serves the BLP register interface.

## Interface
Parameters:
- NUM_CH, 8: number of channels captured (1..32); channels ≥ NUM_CH are ignored
- AVG_LOG2, 3: log2 of samples per average (0..6)
- DATA_W, 12: ADC sample width

Ports:
- Clock_qsys  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- Enable  in  1  capture enable; deasserting it discards partial sums
- RspValid  in  1  ADC response valid (one sample per pulse)
- RspChannel  in  5  ADC channel of current sample
- RspData  in  DATA_W  sample value, unsigned
- RdEn  in  1  read strobe, one cycle
- RdAddress  in  clog2(NUM_CH)  channel to read
- RdData  out  32  registered read data
- RdValid  out  1  one-cycle pulse, RdData valid
- NewData  out  NUM_CH  per-channel sticky "unread result" flags
- Overrun  out  1  sticky; a result replaced an unread result
- OverrunClr  in  1  clears Overrun

## Operation
- Reset values: RdData=0, RdValid=0, NewData=0, Overrun=0, all results/accumulators/counters=0.
- Per channel: accumulator of DATA_W+AVG_LOG2 bits (no overflow possible) and sample counter of AVG_LOG2 bits.
- Sample accepted iff Enable=1, RspValid=1 and RspChannel<NUM_CH. Otherwise it is dropped with no side effect.
- Accepted sample, counter < 2^AVG_LOG2−1: acc += RspData; cnt++.
- Accepted sample, counter = 2^AVG_LOG2−1 (last):
  - result[ch] = (acc+RspData) >> AVG_LOG2 (truncating)
  - acc and cnt reset to 0
  - NewData[ch] set
- Overrun is set when a channel completes while NewData[ch] is already 1 and is not being cleared in the same cycle.
- Read, RdEn=1: next cycle RdValid=1 and RdData={NewData[ch] before clear, 19'b0, result[ch] zero-extended}. NewData[ch] is cleared.
- Read with RdAddress ≥ NUM_CH: RdData=0, RdValid still pulses, no flag changes.
- Read-clear and completion on the same channel in the same cycle:
  - the set wins; NewData stays 1
  - RdData carries the old result and flag=1
  - no Overrun
- Enable=0: all accumulators and counters are forced to 0. Results, NewData, Overrun and the read port remain functional.
- OverrunClr and an Overrun set in the same cycle: set wins.
- Reset asserted at any time, including mid-accumulation or mid-read: all state returns to reset values immediately.

## Timing
- Result latency: result and NewData are updated on the clock edge that samples the last RspValid. They are visible in the next cycle.
- Read latency: 1 cycle, RdEn to RdValid/RdData. Back-to-back RdEn every cycle is supported.
- RdData holds its value until the next read. RdValid is a single-cycle pulse.
- One sample per clock is sustained on any channel mix. There is no backpressure.
- AVG_LOG2=0: every accepted sample completes immediately.

## Configuration
- ADC_COLLECT_AVG_EN defined: averaging as described.
- ADC_COLLECT_AVG_EN undefined:
  - AVG_LOG2 is ignored and no accumulators or counters are built
  - each accepted sample is stored directly as result[ch] and sets NewData[ch]
  - Overrun rules are unchanged

## Structure
- Package adc_collect_pkg holds:
  - DATA_W default and CH_W=5
  - RdData field positions (FLAG_BIT=31, RESULT_LSB=0)
  - the result-register typedef
- Sub-module adc_ch_accum: one channel's accumulator, counter and result register, with a completion output. It is instantiated NUM_CH times via generate.
- The top level holds the channel decode, NewData/Overrun logic and the read mux/register.

## Test plan
- AVG_LOG2=3, ch2 samples 0x100..0x107 back-to-back → result 0x103; NewData[2]=1 the cycle after the 8th sample.
- Read ch2 → RdValid one cycle later, RdData=0x8000_0103, NewData[2]=0. Re-read → 0x0000_0103.
- 8× 0xFFF on ch0, interleaved with samples on channel 9 → ch0 result 0xFFF. Channel 9 leaves no effect and no flags.
- Two completions on ch0 with no read → Overrun=1. OverrunClr → 0. Completion coinciding with a ch0 read → NewData[0]=1, Overrun stays 0.
- 5 samples on ch1, then Enable low for 1 cycle, then 8× 0x010 → result 0x010 (partial sum discarded).
- Reset pulsed asynchronously mid-accumulation and mid-read → all outputs 0 without a clock edge. The next full set of 8 samples averages correctly.
